// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the ID-stage decoder and the hazard sequencer.
// The master drives ID-stage fields and pipeline status; the slave returns control and forwarding.
interface hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_wb_en;
    logic              id_wb_from_mem;
    logic              ex_redirect;
    logic              mem_busy;

    logic              stall_if_id;
    logic              bubble_ex;
    logic              flush_if_id;
    logic              freeze_all;
    logic [1:0]        fwd_rs1_sel;
    logic [1:0]        fwd_rs2_sel;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_wb_en, id_wb_from_mem, ex_redirect, mem_busy,
        input  stall_if_id, bubble_ex, flush_if_id, freeze_all, fwd_rs1_sel, fwd_rs2_sel,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_use_rs1, id_use_rs2,
               id_wb_en, id_wb_from_mem, ex_redirect, mem_busy,
        output stall_if_id, bubble_ex, flush_if_id, freeze_all, fwd_rs1_sel, fwd_rs2_sel,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stall/bubble/flush/freeze, operand forwarding, event counters.
// Build option: define HAZARD_FWD_EN for forwarding mode; undefined gives interlock-only operation.
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);

    // EX/MEM destination tags. The register file writes through, so a WB-stage tag
    // can never cause a hazard and is not held here.
    logic              ex_valid_q, ex_wb_q, mem_valid_q, mem_wb_q;
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q;

    logic             ex_m1, ex_m2, mem_m1, mem_m2, hazard;
    logic             stall, bubble, flush, freeze, load_ex;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        ex_m1  = bus.id_use_rs1 && (bus.id_rs1_addr != '0) && ex_valid_q && ex_wb_q &&
                 (ex_rd_q == bus.id_rs1_addr);
        ex_m2  = bus.id_use_rs2 && (bus.id_rs2_addr != '0) && ex_valid_q && ex_wb_q &&
                 (ex_rd_q == bus.id_rs2_addr);
        mem_m1 = bus.id_use_rs1 && (bus.id_rs1_addr != '0) && mem_valid_q && mem_wb_q &&
                 (mem_rd_q == bus.id_rs1_addr);
        mem_m2 = bus.id_use_rs2 && (bus.id_rs2_addr != '0) && mem_valid_q && mem_wb_q &&
                 (mem_rd_q == bus.id_rs2_addr);
    end

`ifdef HAZARD_FWD_EN
    logic       ex_load_q;
    logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    // Only a load in EX cannot be forwarded in time.
    assign hazard = bus.id_valid && (ex_m1 || ex_m2) && ex_load_q;
`else
    assign hazard = bus.id_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
        // Reset forces the control outputs low regardless of the status inputs.
        if (rst_n) begin
            if (bus.mem_busy) begin
                freeze = 1'b1;
            end else if (bus.ex_redirect) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (hazard) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    assign load_ex = bus.id_valid && !bubble;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_wb_q     <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_wb_q    <= 1'b0;
            mem_rd_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.mem_busy) begin
            mem_valid_q <= ex_valid_q;
            mem_wb_q    <= ex_wb_q;
            mem_rd_q    <= ex_rd_q;
            ex_valid_q  <= load_ex;
            ex_wb_q     <= bus.id_wb_en;
            ex_rd_q     <= bus.id_rd_addr;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef HAZARD_FWD_EN
    // Selects are computed in ID and registered alongside the EX tag, so they apply
    // during the consumer's EX cycle: EX producer then sits in MEM, MEM producer in WB.
    always_comb begin
        fwd1_d = 2'b00;
        fwd2_d = 2'b00;
        if (load_ex) begin
            if (ex_m1)       fwd1_d = 2'b01;
            else if (mem_m1) fwd1_d = 2'b10;
            if (ex_m2)       fwd2_d = 2'b01;
            else if (mem_m2) fwd2_d = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_load_q <= 1'b0;
            fwd1_q    <= 2'b00;
            fwd2_q    <= 2'b00;
        end else if (!bus.mem_busy) begin
            ex_load_q <= bus.id_wb_from_mem;
            fwd1_q    <= fwd1_d;
            fwd2_q    <= fwd2_d;
        end
    end

    assign bus.fwd_rs1_sel = fwd1_q;
    assign bus.fwd_rs2_sel = fwd2_q;
`else
    assign bus.fwd_rs1_sel = 2'b00;
    assign bus.fwd_rs2_sel = 2'b00;
`endif

    assign bus.stall_if_id = stall;
    assign bus.bubble_ex   = bubble;
    assign bus.flush_if_id = flush;
    assign bus.freeze_all  = freeze;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table (interlock build) or hand sequences (forwarding
// build), then load-use saturation on a CNT_W=2 copy and an asynchronous reset mid-stall.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  sat_bus ();

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    hazard_ctrl #(.REG_AW(5), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sat_bus));

    assign sat_bus.id_valid       = bus.id_valid;
    assign sat_bus.id_rs1_addr    = bus.id_rs1_addr;
    assign sat_bus.id_rs2_addr    = bus.id_rs2_addr;
    assign sat_bus.id_rd_addr     = bus.id_rd_addr;
    assign sat_bus.id_use_rs1     = bus.id_use_rs1;
    assign sat_bus.id_use_rs2     = bus.id_use_rs2;
    assign sat_bus.id_wb_en       = bus.id_wb_en;
    assign sat_bus.id_wb_from_mem = bus.id_wb_from_mem;
    assign sat_bus.ex_redirect    = bus.ex_redirect;
    assign sat_bus.mem_busy       = bus.mem_busy;

`ifdef HAZARD_FWD_EN
    localparam int LuStalls = 1;
`else
    localparam int LuStalls = 2;
`endif

    // ctl = {use_rs1, use_rs2, wb_en, wb_from_mem}; env = {ex_redirect, mem_busy};
    // ex = {stall_if_id, bubble_ex, flush_if_id, freeze_all}
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] ctl;
        logic [1:0] env;
        logic [3:0] ex;
        int         sc, fc;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;
    int exp_fc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [3:0] ctl,
                                input logic [1:0] env, input logic [3:0] ex,
                                input int sc, input int fc);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.ctl = ctl; r.env = env;
        r.ex = ex; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [3:0] ctl, input logic [1:0] env);
        bus.id_valid       = v;
        bus.id_rs1_addr    = rs1;
        bus.id_rs2_addr    = rs2;
        bus.id_rd_addr     = rd;
        bus.id_use_rs1     = ctl[3];
        bus.id_use_rs2     = ctl[2];
        bus.id_wb_en       = ctl[1];
        bus.id_wb_from_mem = ctl[0];
        bus.ex_redirect    = env[1];
        bus.mem_busy       = env[0];
    endtask

    // One pipeline cycle: drive after the rising edge, return at the falling edge for sampling.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [3:0] ctl, input logic [1:0] env);
        @(posedge clk);
        #1;
        drive(v, rs1, rs2, rd, ctl, env);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00);
    endtask

    task automatic lw7();
        step(1'b1, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b00);
    endtask

    task automatic cons8();
        step(1'b1, 5'd7, 5'd7, 5'd8, 4'b1110, 2'b00);
    endtask

`ifndef HAZARD_FWD_EN
    vec_t tbl[21];
`endif

    initial begin
        // Reset with redirect and busy asserted: control outputs must still be low.
        drive(1'b1, 5'd1, 5'd1, 5'd1, 4'b1111, 2'b11);
        #12;
        chk("rst_stall", bus.stall_if_id, 0);
        chk("rst_bubble", bus.bubble_ex, 0);
        chk("rst_flush", bus.flush_if_id, 0);
        chk("rst_freeze", bus.freeze_all, 0);
        chk("rst_fwd1", bus.fwd_rs1_sel, 0);
        chk("rst_fwd2", bus.fwd_rs2_sel, 0);
        chk("rst_scnt", bus.stall_count, 0);
        chk("rst_fcnt", bus.flush_count, 0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef HAZARD_FWD_EN
        tbl[0]  = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 0, 0);
        tbl[1]  = mk(1, 1, 2, 5, 4'b1110, 2'b00, 4'b0000, 0, 0); // add x5,x1,x2
        tbl[2]  = mk(1, 5, 1, 6, 4'b1110, 2'b00, 4'b1100, 0, 0); // add x6,x5,x1: distance 1
        tbl[3]  = mk(1, 5, 1, 6, 4'b1110, 2'b00, 4'b1100, 1, 0); // distance 2
        tbl[4]  = mk(1, 5, 1, 6, 4'b1110, 2'b00, 4'b0000, 2, 0);
        tbl[5]  = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 2, 0);
        tbl[6]  = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 2, 0);
        tbl[7]  = mk(1, 0, 0, 0, 4'b1111, 2'b00, 4'b0000, 2, 0); // lw x0
        tbl[8]  = mk(1, 0, 0, 9, 4'b1110, 2'b00, 4'b0000, 2, 0); // add x9,x0,x0
        tbl[9]  = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 2, 0);
        tbl[10] = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 2, 0);
        tbl[11] = mk(1, 2, 0, 7, 4'b1011, 2'b00, 4'b0000, 2, 0); // lw x7
        tbl[12] = mk(1, 7, 7, 8, 4'b1110, 2'b10, 4'b0110, 2, 0); // hazard + redirect
        tbl[13] = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 2, 1);
        tbl[14] = mk(1, 2, 0, 7, 4'b1011, 2'b00, 4'b0000, 2, 1); // lw x7
        tbl[15] = mk(1, 7, 7, 8, 4'b1110, 2'b01, 4'b0001, 2, 1); // busy x3
        tbl[16] = mk(1, 7, 7, 8, 4'b1110, 2'b01, 4'b0001, 2, 1);
        tbl[17] = mk(1, 7, 7, 8, 4'b1110, 2'b01, 4'b0001, 2, 1);
        tbl[18] = mk(1, 7, 7, 8, 4'b1110, 2'b00, 4'b1100, 2, 1);
        tbl[19] = mk(1, 7, 7, 8, 4'b1110, 2'b00, 4'b1100, 3, 1);
        tbl[20] = mk(0, 0, 0, 0, 4'b0000, 2'b00, 4'b0000, 4, 1);
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].ctl, tbl[i].env);
            chk($sformatf("v%0d_stall", i), bus.stall_if_id, tbl[i].ex[3]);
            chk($sformatf("v%0d_bubble", i), bus.bubble_ex, tbl[i].ex[2]);
            chk($sformatf("v%0d_flush", i), bus.flush_if_id, tbl[i].ex[1]);
            chk($sformatf("v%0d_freeze", i), bus.freeze_all, tbl[i].ex[0]);
            chk($sformatf("v%0d_fwd", i), {bus.fwd_rs1_sel, bus.fwd_rs2_sel}, 0);
            chk($sformatf("v%0d_scnt", i), bus.stall_count, tbl[i].sc);
            chk($sformatf("v%0d_fcnt", i), bus.flush_count, tbl[i].fc);
            chk($sformatf("v%0d_sat_scnt", i), sat_bus.stall_count, sat3(tbl[i].sc));
            chk($sformatf("v%0d_sat_fcnt", i), sat_bus.flush_count, sat3(tbl[i].fc));
        end
        exp_sc = 4;
        exp_fc = 1;
`else
        idle();
        step(1'b1, 5'd1, 5'd2, 5'd5, 4'b1110, 2'b00);
        chk("alu_prod_stall", bus.stall_if_id, 0);
        step(1'b1, 5'd5, 5'd1, 5'd6, 4'b1110, 2'b00);
        chk("alu_cons_stall", bus.stall_if_id, 0);
        idle();
        chk("alu_fwd1", bus.fwd_rs1_sel, 2'b01);
        chk("alu_fwd2", bus.fwd_rs2_sel, 2'b00);
        idle();
        lw7();
        cons8();
        chk("lu_stall", bus.stall_if_id, 1);
        chk("lu_bubble", bus.bubble_ex, 1);
        exp_sc = 1;
        cons8();
        chk("lu_release", bus.stall_if_id, 0);
        chk("lu_bubble_fwd", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}, 0);
        idle();
        chk("lu_fwd1", bus.fwd_rs1_sel, 2'b10);
        chk("lu_fwd2", bus.fwd_rs2_sel, 2'b10);
        idle();
        step(1'b1, 5'd0, 5'd0, 5'd0, 4'b1111, 2'b00);
        step(1'b1, 5'd0, 5'd0, 5'd9, 4'b1110, 2'b00);
        chk("x0_stall", bus.stall_if_id, 0);
        idle();
        chk("x0_fwd", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}, 0);
        chk("fwd_scnt", bus.stall_count, exp_sc);
`endif

        // Repeated load-use pairs drive the 2-bit copy into saturation.
        for (int k = 0; k < 4; k++) begin
            lw7();
            chk($sformatf("lu%0d_lw", k), bus.stall_if_id, 0);
            for (int j = 0; j < LuStalls; j++) begin
                cons8();
                chk($sformatf("lu%0d_stall%0d", k, j), bus.stall_if_id, 1);
                exp_sc++;
            end
            cons8();
            chk($sformatf("lu%0d_go", k), bus.stall_if_id, 0);
            idle();
        end
        chk("loop_scnt", bus.stall_count, exp_sc);
        chk("loop_fcnt", bus.flush_count, exp_fc);
        chk("sat_scnt", sat_bus.stall_count, sat3(exp_sc));
        chk("sat_fcnt", sat_bus.flush_count, sat3(exp_fc));

        // Asynchronous reset in the middle of a stall.
        lw7();
        cons8();
        chk("pre_rst_stall", bus.stall_if_id, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", bus.stall_if_id, 0);
        chk("arst_bubble", bus.bubble_ex, 0);
        chk("arst_scnt", bus.stall_count, 0);
        chk("arst_fcnt", bus.flush_count, 0);
        chk("arst_sat_scnt", sat_bus.stall_count, 0);
        chk("arst_fwd", {bus.fwd_rs1_sel, bus.fwd_rs2_sel}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", bus.stall_if_id, 0);
        chk("post_rst_bubble", bus.bubble_ex, 0);
        idle();
        chk("post_rst_scnt", bus.stall_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
